// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO registers
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_div_zero;
  logic               r_q_neg;
  logic               r_r_neg;
  logic [WIDTH-1:0]   r_opnd_b;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_signed;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_div_zero;
  logic               w_accept;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // Operand conditioning: signed ops (op[0]==0) iterate on magnitudes and fix signs at the end.
  always_comb begin
    w_signed   = ~op[0];
    w_neg_a    = w_signed & src_a[WIDTH-1];
    w_neg_b    = w_signed & src_b[WIDTH-1];
    w_mag_a    = w_neg_a ? ('0 - src_a) : src_a;
    w_mag_b    = w_neg_b ? ('0 - src_b) : src_b;
    w_div_zero = op[1] & (src_b == '0);
    w_accept   = (r_state == S_IDLE) & start & ~flush;
  end

  // One iteration step: shift-add multiply and restoring divide share the accumulator pair.
  always_comb begin
    w_add      = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd_b} : '0);
    w_shift    = {r_acc_hi, r_acc_lo[WIDTH-1]};
    w_ge       = (w_shift >= {1'b0, r_opnd_b});
    w_sub      = w_shift[WIDTH-1:0] - r_opnd_b;
    w_prod     = {r_acc_hi, r_acc_lo};
    w_prod_fix = r_q_neg ? ('0 - w_prod) : w_prod;
    w_quo_fix  = r_q_neg ? ('0 - r_acc_lo) : r_acc_lo;
    w_rem_fix  = r_r_neg ? ('0 - r_acc_hi) : r_acc_hi;
  end

  // Next-state logic: divide by zero skips the iteration phase; flush always returns to idle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_div_zero ? S_FIXUP : S_CALC;
      end
      S_CALC: begin
        if (flush)              w_next = S_IDLE;
        else if (r_cnt == '0)   w_next = S_FIXUP;
      end
      S_FIXUP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Datapath: latch operands, iterate, then commit HI/LO and pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_div_zero <= 1'b0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_opnd_b   <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mthi_we) r_hi <= src_a;
          if (mtlo_we) r_lo <= src_a;
          if (w_accept) begin
            r_cnt      <= CNT_W'(WIDTH - 1);
            r_is_div   <= op[1];
            r_div_zero <= w_div_zero;
            r_q_neg    <= w_neg_a ^ w_neg_b;
            r_r_neg    <= w_neg_a;
            r_opnd_b   <= w_mag_b;
            r_acc_hi   <= '0;
            r_acc_lo   <= w_div_zero ? src_a : w_mag_a;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_is_div) begin
            r_acc_hi <= w_ge ? w_sub : w_shift[WIDTH-1:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
          end else begin
            r_acc_hi <= w_add[WIDTH:1];
            r_acc_lo <= {w_add[0], r_acc_lo[WIDTH-1:1]};
          end
        end
        S_FIXUP: begin
          if (!flush) begin
            r_done <= 1'b1;
            if (r_div_zero) begin
              r_hi <= r_acc_lo;
              r_lo <= '1;
            end else if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule
